// File: rtl/q1.sv
// 4-bit registered code converter: binary->Gray when s=1, Gray->binary when s=0.
// Output register loads every cycle; rst clears it synchronously.
module q1 (
  input  logic clk,
  input  logic rst,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic s,
  output logic a0,
  output logic a1,
  output logic a2,
  output logic a3
);

  logic [3:0] b_word;
  logic [3:0] gray_word;
  logic [3:0] bin_word;
  logic [3:0] a_next;
  logic [3:0] a_reg;

  assign b_word = {b3, b2, b1, b0};

  assign gray_word[3] = b_word[3];
  assign bin_word[3]  = b_word[3];

  // Gray bit i pairs adjacent inputs; binary bit i is the parity of all inputs at or above i.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_conv
      assign gray_word[gi] = b_word[gi+1] ^ b_word[gi];
      assign bin_word[gi]  = ^b_word[3:gi];
    end
  endgenerate

  assign a_next = s ? gray_word : bin_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= 4'b0000;
    end else begin
      a_reg <= a_next;
    end
  end

  assign {a3, a2, a1, a0} = a_reg;

endmodule

// File: tb/tb_q1.sv
// Directed bench for q1: vector table, exhaustive round trip, and
// checks that outputs only move on clock edges.
module tb_q1;

  logic clk;
  logic rst;
  logic b0, b1, b2, b3;
  logic s;
  logic a0, a1, a2, a3;

  int n_vec;
  int n_bad;

  q1 dut (
    .clk(clk),
    .rst(rst),
    .b0(b0),
    .b1(b1),
    .b2(b2),
    .b3(b3),
    .s(s),
    .a0(a0),
    .a1(a1),
    .a2(a2),
    .a3(a3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       s;
    logic [3:0] b;
    logic [3:0] exp_a;
  } vec_t;

  vec_t vecs[13];
  logic [3:0] g_cap[16];

  function automatic logic [3:0] a_word();
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end else begin
      $display("ok   %s: a=%b", name, got);
    end
  endtask

  task automatic drive(input logic r, input logic sel, input logic [3:0] bw);
    rst = r;
    s = sel;
    {b3, b2, b1, b0} = bw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] held;
    n_vec = 0;
    n_bad = 0;

    vecs[0]  = '{"reset_edge1",     1'b1, 1'b1, 4'b1111, 4'b0000};
    vecs[1]  = '{"reset_edge2",     1'b1, 1'b1, 4'b1111, 4'b0000};
    vecs[2]  = '{"release_b2g_1111",1'b0, 1'b1, 4'b1111, 4'b1000};
    vecs[3]  = '{"b2g_0110",        1'b0, 1'b1, 4'b0110, 4'b0101};
    vecs[4]  = '{"g2b_0110",        1'b0, 1'b0, 4'b0110, 4'b0100};
    vecs[5]  = '{"b2g_1111",        1'b0, 1'b1, 4'b1111, 4'b1000};
    vecs[6]  = '{"g2b_1000",        1'b0, 1'b0, 4'b1000, 4'b1111};
    vecs[7]  = '{"g2b_1111",        1'b0, 1'b0, 4'b1111, 4'b1010};
    vecs[8]  = '{"b2g_1010",        1'b0, 1'b1, 4'b1010, 4'b1111};
    vecs[9]  = '{"stream_b2g_0011", 1'b0, 1'b1, 4'b0011, 4'b0010};
    vecs[10] = '{"mid_reset",       1'b1, 1'b1, 4'b0011, 4'b0000};
    vecs[11] = '{"resume_0011",     1'b0, 1'b1, 4'b0011, 4'b0010};
    vecs[12] = '{"g2b_0001",        1'b0, 1'b0, 4'b0001, 4'b0001};

    drive(1'b1, 1'b1, 4'b1111);
    #2;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].s, vecs[i].b);
      step();
      check(vecs[i].name, a_word(), vecs[i].exp_a);
    end

    // Inputs change between edges must not reach the output until the next edge.
    held = a_word();
    drive(1'b0, 1'b1, 4'b1100);
    #2;
    check("hold_between_edges", a_word(), held);
    step();
    check("b2g_1100", a_word(), 4'b1010);

    // Forward pass: capture Gray for every value, checked against v ^ (v >> 1).
    for (int v = 0; v < 16; v++) begin
      logic [3:0] vv;
      vv = 4'(v);
      drive(1'b0, 1'b1, vv);
      step();
      g_cap[v] = a_word();
      check($sformatf("gray_of_%0d", v), g_cap[v], vv ^ (vv >> 1));
    end

    // Reverse pass: decoding each captured Gray code must return the original value.
    for (int v = 0; v < 16; v++) begin
      drive(1'b0, 1'b0, g_cap[v]);
      step();
      check($sformatf("roundtrip_%0d", v), a_word(), 4'(v));
    end

    // Adjacent binary codes must map to Gray codes one bit apart.
    for (int v = 1; v < 16; v++) begin
      check($sformatf("adjacent_%0d_%0d", v - 1, v),
            4'($countones(g_cap[v] ^ g_cap[v-1])), 4'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/q1.md
Name: q1

Overview:
- 4-bit registered code converter with selectable direction.
- s=1: binary -> Gray. s=0: Gray -> binary.
- Input word is {b3,b2,b1,b0}; output word is {a3,a2,a1,a0}. Bit 3 is the MSB.
- Standalone leaf block for small datapath/encoder exercises. Single clock domain.

Parameters:
- none. Width is fixed at 4 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- b0  input  1  input word bit 0 (LSB).
- b1  input  1  input word bit 1.
- b2  input  1  input word bit 2.
- b3  input  1  input word bit 3 (MSB).
- s  input  1  mode select: 1 = binary->Gray, 0 = Gray->binary.
- a0  output  1  converted word bit 0 (LSB), registered.
- a1  output  1  converted word bit 1, registered.
- a2  output  1  converted word bit 2, registered.
- a3  output  1  converted word bit 3 (MSB), registered.

Behaviour:
- One clock, synchronous active-high reset: clk, rst.
- Reset:
  - If rst=1 at a rising clk edge, {a3..a0} <= 4'b0000.
  - Reset takes priority over any input.
  - Deasserting rst has no effect until the next edge.
- Conversion is combinational from b and s. Result is captured into the output register on every rising edge while rst=0.
- Latency is exactly 1 cycle: outputs reflect the b/s values sampled at the previous edge.
- Outputs change only on clock edges. There is no enable; the register loads every cycle.
- Binary->Gray (s=1):
  - a3=b3
  - a2=b3^b2
  - a1=b2^b1
  - a0=b1^b0
- Gray->binary (s=0):
  - a3=b3
  - a2=b3^b2
  - a1=b3^b2^b1
  - a0=b3^b2^b1^b0
- Changing s between cycles: the new mode applies from the next edge. There is no pipeline state to flush.
- Reset mid-stream: the output is forced to 0000 on that edge. Normal conversion resumes on the first edge with rst=0.
- X/Z handling: not required. Inputs are assumed driven by the environment before the first non-reset edge.
- No internal state other than the 4-bit output register.

Test Plan:
- Hold rst=1 for 2 edges with b=1111, s=1 -> a=0000 after each edge. Release rst -> next edge gives a=1000.
- rst=0, s=1, b={b3..b0}=0110 -> a=0101 one edge later.
- rst=0, s=0, b=0110 -> a=0100 one edge later.
- s=1, b=1111 -> a=1000. Then s=0, b=1000 -> a=1111 one edge later.
- Exhaustive round trip: for all 16 values v, apply s=1, b=v, and capture g. Then apply s=0, b=g -> a must equal v. Also confirm that adjacent binary codes produce Gray outputs differing in exactly 1 bit.
- Reset mid-operation: streaming s=1 with b=0011 (a=0010), assert rst for 1 edge -> a=0000. Deassert -> next edge a=0010 again.
